// File: rtl/logic_gates_sequencer_if.sv
// Sequencer <-> gate unit / controller bundle; master side is the sequencer.
// LGS_FAIL_CAPTURE_EN adds the first-failure capture signals.
interface logic_gates_sequencer_if;
  logic       iStart;
  logic       iAbort;
  logic       iAnd;
  logic       iOr;
  logic       iNot;
  logic       oA;
  logic       oB;
  logic       oBusy;
  logic       oDone;
  logic       oPass;
  logic [2:0] oErrCnt;
  logic [1:0] oVec;
`ifdef LGS_FAIL_CAPTURE_EN
  logic       oFailValid;
  logic [1:0] oFailVec;
  logic [2:0] oFailBits;
`endif

  modport master (
    input  iStart, iAbort, iAnd, iOr, iNot,
    output oA, oB, oBusy, oDone, oPass, oErrCnt, oVec
`ifdef LGS_FAIL_CAPTURE_EN
    , output oFailValid, oFailVec, oFailBits
`endif
  );

  modport slave (
    output iStart, iAbort, iAnd, iOr, iNot,
    input  oA, oB, oBusy, oDone, oPass, oErrCnt, oVec
`ifdef LGS_FAIL_CAPTURE_EN
    , input oFailValid, oFailVec, oFailBits
`endif
  );
endinterface

// File: rtl/logic_gates_sequencer.sv
// Gate-unit self-test: drives (A,B)=00,10,01,11 for HOLD_CYCLES each, oDone one cycle after edge t+4*HOLD_CYCLES.
// No backpressure: iStart ignored outside IDLE, iAbort ends a run next edge; LGS_FAIL_CAPTURE_EN adds first-failure capture.
module logic_gates_sequencer #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input logic                     iClk,
  input logic                     iRst,
  logic_gates_sequencer_if.master seqIf
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  state_t           stateNxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       vec;
  logic [2:0]       errCnt;
  logic             pass;
  logic [2:0]       failBits;
  logic             vecFail;
  logic             lastDwell;
  logic             startOk;

  assign startOk   = seqIf.iStart && !seqIf.iAbort;
  assign lastDwell = (cnt == '0);
  // {and, or, not} mismatch against the truth table for A=vec[0], B=vec[1]
  assign failBits  = {seqIf.iAnd ^ (vec[0] & vec[1]),
                      seqIf.iOr  ^ (vec[0] | vec[1]),
                      seqIf.iNot ^ ~vec[0]};
  assign vecFail   = |failBits;

  always_ff @(posedge iClk) begin
    if (iRst) state <= IDLE;
    else      state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (startOk) stateNxt = RUN;
      RUN: begin
        if (seqIf.iAbort)                       stateNxt = IDLE;
        else if (lastDwell && (vec == 2'd3))    stateNxt = DONE;
      end
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_comb begin
    seqIf.oBusy = (state == RUN);
    seqIf.oDone = (state == DONE);
    seqIf.oA    = (state == RUN) ? vec[0] : 1'b0;
    seqIf.oB    = (state == RUN) ? vec[1] : 1'b0;
    seqIf.oVec  = (state == RUN) ? vec : 2'd0;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt    <= '0;
      vec    <= '0;
      errCnt <= '0;
      pass   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (startOk) begin
            cnt    <= RELOAD;
            vec    <= '0;
            errCnt <= '0;
            pass   <= 1'b0;
          end
        end
        RUN: begin
          if (seqIf.iAbort) begin
            pass <= 1'b0;
          end else if (!lastDwell) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (vecFail) errCnt <= errCnt + 3'd1;
            if (vec == 2'd3) begin
              pass <= (errCnt == 3'd0) && !vecFail;
            end else begin
              vec <= vec + 2'd1;
              cnt <= RELOAD;
            end
          end
        end
        DONE: if (seqIf.iAbort) pass <= 1'b0;
        default: ;
      endcase
    end
  end

  assign seqIf.oPass   = pass;
  assign seqIf.oErrCnt = errCnt;

`ifdef LGS_FAIL_CAPTURE_EN
  logic       failValid;
  logic [1:0] failVec;
  logic [2:0] failBitsQ;

  // First failure of a run sticks until reset or the next accepted start.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      failValid <= 1'b0;
      failVec   <= '0;
      failBitsQ <= '0;
    end else if (state == IDLE && startOk) begin
      failValid <= 1'b0;
      failVec   <= '0;
      failBitsQ <= '0;
    end else if (state == RUN && !seqIf.iAbort && lastDwell && vecFail && !failValid) begin
      failValid <= 1'b1;
      failVec   <= vec;
      failBitsQ <= failBits;
    end
  end

  assign seqIf.oFailValid = failValid;
  assign seqIf.oFailVec   = failVec;
  assign seqIf.oFailBits  = failBitsQ;
`endif
endmodule

// File: tb/tb_logic_gates_sequencer.sv
// Bench: two sequencers (HOLD 4 and HOLD 1) against a fault-injectable gate model and a truth-table reference.
module tb_logic_gates_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1:0] rstV;
  logic [1:0] startV;
  logic [1:0] abortV;
  logic [2:0] fMask [2];
  logic [2:0] fVal  [2];

  logic_gates_sequencer_if if4 ();
  logic_gates_sequencer_if if1 ();

  logic_gates_sequencer #(.HOLD_CYCLES(4), .CNT_W(8)) dut4 (.iClk(clk), .iRst(rstV[0]), .seqIf(if4));
  logic_gates_sequencer #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (.iClk(clk), .iRst(rstV[1]), .seqIf(if1));

  assign if4.iStart = startV[0];
  assign if4.iAbort = abortV[0];
  assign if1.iStart = startV[1];
  assign if1.iAbort = abortV[1];

  // Gate unit model: each output either ideal or stuck at fVal, bit order {and, or, not}.
  always_comb begin
    if4.iAnd = fMask[0][2] ? fVal[0][2] : (if4.oA & if4.oB);
    if4.iOr  = fMask[0][1] ? fVal[0][1] : (if4.oA | if4.oB);
    if4.iNot = fMask[0][0] ? fVal[0][0] : ~if4.oA;
  end
  always_comb begin
    if1.iAnd = fMask[1][2] ? fVal[1][2] : (if1.oA & if1.oB);
    if1.iOr  = fMask[1][1] ? fVal[1][1] : (if1.oA | if1.oB);
    if1.iNot = fMask[1][0] ? fVal[1][0] : ~if1.oA;
  end

  logic [1:0] busyO, doneO, passO, aO, bO;
  logic [2:0] errO [2];
  logic [1:0] vecO [2];
  assign busyO = {if1.oBusy, if4.oBusy};
  assign doneO = {if1.oDone, if4.oDone};
  assign passO = {if1.oPass, if4.oPass};
  assign aO    = {if1.oA, if4.oA};
  assign bO    = {if1.oB, if4.oB};
  assign errO[0] = if4.oErrCnt;
  assign errO[1] = if1.oErrCnt;
  assign vecO[0] = if4.oVec;
  assign vecO[1] = if1.oVec;
`ifdef LGS_FAIL_CAPTURE_EN
  logic [1:0] fvO;
  logic [1:0] fVecO [2];
  logic [2:0] fBitsO [2];
  assign fvO = {if1.oFailValid, if4.oFailValid};
  assign fVecO[0] = if4.oFailVec;
  assign fVecO[1] = if1.oFailVec;
  assign fBitsO[0] = if4.oFailBits;
  assign fBitsO[1] = if1.oFailBits;
`endif

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the four vectors, compare faulty outputs to the truth table.
  task automatic refModel(input logic [2:0] mask, input logic [2:0] val, output int nErr,
                          output int firstVec, output logic [2:0] firstBits);
    nErr = 0; firstVec = 0; firstBits = 3'b000;
    for (int v = 0; v < 4; v++) begin
      int a = v % 2;
      int b = v / 2;
      int ideal [3];
      logic [2:0] mis;
      ideal[2] = a * b;
      ideal[1] = (a + b > 0) ? 1 : 0;
      ideal[0] = 1 - a;
      mis = 3'b000;
      for (int k = 0; k < 3; k++)
        if (mask[k] && (int'(val[k]) != ideal[k])) mis[k] = 1'b1;
      if (mis != 3'b000) begin
        if (nErr == 0) begin firstVec = v; firstBits = mis; end
        nErr++;
      end
    end
  endtask

  // Runs one full sequence and returns at the DONE cycle with its checks done.
  task automatic doRun(input int d, input int hold, input logic [2:0] mask, input logic [2:0] val,
                       output int expErr, output logic expPass);
    int fv;
    logic [2:0] fb;
    refModel(mask, val, expErr, fv, fb);
    expPass = (expErr == 0);
    fMask[d] = mask;
    fVal[d]  = val;
    startV[d] = 1'b1;
    tick();
    for (int k = 1; k <= 4 * hold; k++) begin
      int v = (k - 1) / hold;
      check("run_busy", 8'(busyO[d]), 8'd1);
      check("run_vec",  8'(vecO[d]), 8'(v));
      check("run_a",    8'(aO[d]), 8'(v % 2));
      check("run_b",    8'(bO[d]), 8'(v / 2));
      check("run_nodone", 8'(doneO[d]), 8'd0);
      startV[d] = 1'($urandom_range(0, 1));
      tick();
    end
    startV[d] = 1'b0;
    check("done_pulse", 8'(doneO[d]), 8'd1);
    check("done_busy",  8'(busyO[d]), 8'd0);
    check("done_a",     8'(aO[d]), 8'd0);
    check("done_b",     8'(bO[d]), 8'd0);
    check("done_err",   8'(errO[d]), 8'(expErr));
    check("done_pass",  8'(passO[d]), 8'(expPass));
`ifdef LGS_FAIL_CAPTURE_EN
    check("done_fvalid", 8'(fvO[d]), 8'(expErr != 0));
    check("done_fvec",   8'(fVecO[d]), 8'(fv));
    check("done_fbits",  8'(fBitsO[d]), 8'(fb));
`endif
  endtask

  task automatic afterDone(input int d, input int expErr, input logic expPass);
    tick();
    check("post_done", 8'(doneO[d]), 8'd0);
    check("post_busy", 8'(busyO[d]), 8'd0);
    check("hold_err",  8'(errO[d]), 8'(expErr));
    check("hold_pass", 8'(passO[d]), 8'(expPass));
  endtask

  initial begin
    int e;
    logic p;
    rstV = 2'b11; startV = 2'b00; abortV = 2'b00;
    fMask[0] = 3'b000; fVal[0] = 3'b000;
    fMask[1] = 3'b000; fVal[1] = 3'b000;
    @(negedge clk);
    tick();
    tick();
    rstV = 2'b00;
    for (int d = 0; d < 2; d++) begin
      check("rst_a", 8'(aO[d]), 8'd0);
      check("rst_b", 8'(bO[d]), 8'd0);
      check("rst_busy", 8'(busyO[d]), 8'd0);
      check("rst_done", 8'(doneO[d]), 8'd0);
      check("rst_pass", 8'(passO[d]), 8'd0);
      check("rst_err", 8'(errO[d]), 8'd0);
      check("rst_vec", 8'(vecO[d]), 8'd0);
    end

    // Ideal, AND stuck 0, NOT stuck 0 on the HOLD=4 unit.
    doRun(0, 4, 3'b000, 3'b000, e, p); afterDone(0, e, p);
    doRun(0, 4, 3'b100, 3'b000, e, p); afterDone(0, e, p);
    doRun(0, 4, 3'b001, 3'b000, e, p); afterDone(0, e, p);

    // Start with abort in IDLE: abort wins.
    startV[0] = 1'b1; abortV[0] = 1'b1; tick();
    startV[0] = 1'b0; abortV[0] = 1'b0;
    check("idle_abort_busy", 8'(busyO[0]), 8'd0);

    // Abort at edge 6 with NOT stuck 0; start at edge 3 ignored.
    fMask[0] = 3'b001; fVal[0] = 3'b000;
    doRun(0, 4, 3'b000, 3'b000, e, p); afterDone(0, e, p);
    fMask[0] = 3'b001;
    startV[0] = 1'b1; tick(); startV[0] = 1'b0;
    tick(); tick();
    startV[0] = 1'b1; tick(); startV[0] = 1'b0;
    check("abort_busy3", 8'(busyO[0]), 8'd1);
    check("abort_vec3", 8'(vecO[0]), 8'd0);
    tick();
    check("abort_vec4", 8'(vecO[0]), 8'd1);
    check("abort_err4", 8'(errO[0]), 8'd1);
    tick();
    abortV[0] = 1'b1; tick(); abortV[0] = 1'b0;
    check("abort_busy", 8'(busyO[0]), 8'd0);
    check("abort_a", 8'(aO[0]), 8'd0);
    check("abort_b", 8'(bO[0]), 8'd0);
    check("abort_pass", 8'(passO[0]), 8'd0);
    check("abort_err", 8'(errO[0]), 8'd1);
    for (int k = 0; k < 12; k++) begin
      check("abort_nodone", 8'(doneO[0]), 8'd0);
      tick();
    end

    // Reset at edge 9 mid-run, then a clean run passes.
    fMask[0] = 3'b001; fVal[0] = 3'b000;
    startV[0] = 1'b1; tick(); startV[0] = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    check("mid_err", 8'(errO[0]), 8'd1);
    check("mid_vec", 8'(vecO[0]), 8'd2);
    rstV[0] = 1'b1; tick(); rstV[0] = 1'b0;
    check("rst9_busy", 8'(busyO[0]), 8'd0);
    check("rst9_done", 8'(doneO[0]), 8'd0);
    check("rst9_err", 8'(errO[0]), 8'd0);
    check("rst9_a", 8'(aO[0]), 8'd0);
    check("rst9_vec", 8'(vecO[0]), 8'd0);
    tick();
    check("rst9_idle", 8'(busyO[0]), 8'd0);
    doRun(0, 4, 3'b000, 3'b000, e, p); afterDone(0, e, p);

    // HOLD=1: back-to-back start in the DONE cycle ignored, one cycle later accepted.
    doRun(1, 1, 3'b000, 3'b000, e, p);
    startV[1] = 1'b1; tick();
    check("b2b_ignored", 8'(busyO[1]), 8'd0);
    check("b2b_nodone", 8'(doneO[1]), 8'd0);
    tick(); startV[1] = 1'b0;
    check("b2b_accept", 8'(busyO[1]), 8'd1);
    check("b2b_vec0", 8'(vecO[1]), 8'd0);
    tick(); tick(); tick();
    check("b2b_vec3", 8'(vecO[1]), 8'd3);
    tick();
    check("b2b_done", 8'(doneO[1]), 8'd1);
    check("b2b_pass", 8'(passO[1]), 8'd1);
    tick();

    // Random stuck-at faults on either unit.
    for (int r = 0; r < 10; r++) begin
      int d = int'($urandom_range(0, 1));
      logic [2:0] m = 3'($urandom_range(0, 7));
      logic [2:0] v = 3'($urandom_range(0, 7));
      doRun(d, (d == 0) ? 4 : 1, m, v, e, p);
      afterDone(d, e, p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/logic_gates_sequencer.md
Name: logic_gates_sequencer

Overview:
Self-test sequencer for the two-input logic gate unit (AND/OR/NOT). On a start request it drives every (A,B) input combination onto the gate unit in a fixed order and holds each one for a programmable dwell time. At the end of each dwell it samples the gate outputs and compares them against the truth table. It then reports completion, pass/fail and a mismatch count. The gate unit stays a pure combinational datapath; this block owns its inputs while a run is in progress.

Parameters:
HOLD_CYCLES, 4, dwell per vector in clock cycles; legal range 1..255.
CNT_W, 8, width of the dwell counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
iClk  input  1  clock; all state changes on rising edge
iRst  input  1  reset; synchronous, active-high
iStart  input  1  run request; sampled only in IDLE
iAbort  input  1  terminate run immediately
iAnd  input  1  gate unit AND output
iOr  input  1  gate unit OR output
iNot  input  1  gate unit NOT output (NOT of A)
oA  output  1  gate unit input A
oB  output  1  gate unit input B
oBusy  output  1  high while a run is in progress
oDone  output  1  one-cycle pulse at run completion
oPass  output  1  1 if the last completed run had zero mismatches
oErrCnt  output  3  number of failing vectors in the current/last run (0..4)
oVec  output  2  index of the vector currently applied

Behaviour:
- Interface: one clock, iClk. Reset iRst is synchronous and active-high.
- Reset values (all outputs 0): oA, oB, oBusy, oDone, oPass, oErrCnt, oVec. State returns to IDLE.
- Vector mapping: oA = vec[0], oB = vec[1]. Order is vec 0,1,2,3, i.e. (A,B) = 00, 10, 01, 11.
- Expected results: AND = A&B, OR = A|B, NOT = ~A. A vector fails if any of the three outputs mismatches. Each failing vector counts once.
- States:
  - IDLE: oA = oB = 0, oBusy = 0.
  - RUN: oBusy = 1, oA/oB driven from vec.
  - DONE: lasts exactly one cycle, oDone = 1, then returns to IDLE.
- Start: edge with IDLE and iStart=1 and iAbort=0 → RUN, vec=0, cnt=HOLD_CYCLES-1, oErrCnt=0, oPass=0.
- RUN, each edge:
  - If cnt != 0: cnt decrements.
  - If cnt == 0: compare iAnd/iOr/iNot against expected for the current vec. On mismatch, oErrCnt increments.
  - Then, if vec == 3: go to DONE and set oPass = (final error count == 0), including the current vector.
  - Otherwise: vec increments and cnt reloads HOLD_CYCLES-1.
- Latency: with start sampled at edge t, oDone is high in the cycle following edge t+4*HOLD_CYCLES. Each vector is driven for exactly HOLD_CYCLES cycles.
- Inputs are sampled only on the last dwell cycle, so gate settling glitches are ignored.
- oPass and oErrCnt hold their values until the next accepted start.
- iStart while in RUN or DONE is ignored; it is not queued.
- iAbort in RUN or DONE: next edge → IDLE, no oDone pulse, oPass = 0, oErrCnt holds its partial count. iAbort in IDLE has no effect.
- iStart and iAbort asserted together in IDLE: abort wins, stay in IDLE.
- iRst mid-run: reset values apply on the next edge, no oDone pulse. Reset has priority over abort and start.
- HOLD_CYCLES = 1: cnt is always 0; one vector per cycle, oDone after edge t+4.

Optional Feature:
Macro LGS_FAIL_CAPTURE_EN.
- Defined: adds three outputs:
  - oFailValid (1 bit)
  - oFailVec (2 bits)
  - oFailBits (3 bits, {and_mismatch, or_mismatch, not_mismatch})
- These capture the first failing vector of a run. All three clear on reset and on an accepted start. Once oFailValid = 1, later failures in the same run do not overwrite the capture. The captured values are held through abort and DONE.
- Not defined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. HOLD=4, ideal gate model, iStart pulsed at edge 0 → oBusy=1 from edge 0 to 16; oA/oB step 00,10,01,11 every 4 cycles; oDone pulse after edge 16; oPass=1, oErrCnt=0.
2. HOLD=4, AND stuck at 0 → only vec 3 fails: oErrCnt=1, oPass=0. With LGS_FAIL_CAPTURE_EN: oFailVec=3, oFailBits=3'b100.
3. HOLD=4, NOT stuck at 0 → vecs 0 and 2 fail: oErrCnt=2, oPass=0. With the macro: oFailVec=0, oFailBits=3'b001, not overwritten by vec 2.
4. iAbort at edge 6 during a run → oBusy=0 and oA=oB=0 after edge 6; no oDone; oPass=0. An iStart at edge 3 is ignored, so the run length is unaffected.
5. iRst asserted at edge 9 mid-run → all outputs 0 after edge 9, state IDLE. A subsequent iStart runs a full sequence and passes.
6. HOLD=1, ideal model → oVec=0,1,2,3 on consecutive cycles; oDone after edge 4; oPass=1. Back-to-back iStart in the oDone cycle is ignored; iStart one cycle later is accepted.
